// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters; PSEL decoded from PADDR[27:24].
// Four cycles per transfer plus one per wait state; requesters hold REQ until DONE; stalled ACCESS aborts after TIMEOUT waits.
module apb_master_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ-1:0]      REQ_WRITE,
    input  logic [NREQ*32-1:0]   REQ_ADDR,
    input  logic [NREQ*32-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]      DONE,
    output logic [31:0]          RDATA,
    output logic                 ERR,
    output logic                 TIMEOUT_EV,
    output logic [31:0]          PADDR,
    output logic [15:0]          PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   rr_q;
    logic [IW-1:0]   gnt_q;
    logic [15:0]     wait_q;
    logic [NREQ-1:0] done_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic            tev_q;
    logic [31:0]     paddr_q;
    logic [15:0]     psel_q;
    logic            penable_q;
    logic            pwrite_q;
    logic [31:0]     pwdata_q;

    logic            win_vld_d;
    logic [IW-1:0]   win_d;
    logic [IW-1:0]   rr_d;
    logic [31:0]     addr_d;
    logic [31:0]     wdata_d;
    logic            write_d;

    // Two passes: first requesters at or above rr, then the wrapped-around ones below it.
    always_comb begin
        win_vld_d = 1'b0;
        win_d     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_vld_d && REQ[i] && (IW'(i) >= rr_q)) begin
                win_vld_d = 1'b1;
                win_d     = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!win_vld_d && REQ[i]) begin
                win_vld_d = 1'b1;
                win_d     = IW'(i);
            end
        end
        rr_d    = (win_d == IW'(NREQ - 1)) ? '0 : win_d + IW'(1);
        addr_d  = '0;
        wdata_d = '0;
        write_d = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_d == IW'(i)) begin
                addr_d  = REQ_ADDR[32*i +: 32];
                wdata_d = REQ_WDATA[32*i +: 32];
                write_d = REQ_WRITE[i];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            gnt_q     <= '0;
            wait_q    <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            tev_q     <= 1'b0;
            paddr_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q  <= '0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    tev_q   <= 1'b0;
                    if (win_vld_d) begin
                        state_q  <= S_SETUP;
                        gnt_q    <= win_d;
                        rr_q     <= rr_d;
                        paddr_q  <= addr_d;
                        pwrite_q <= write_d;
                        pwdata_q <= wdata_d;
                        psel_q   <= 16'd1 << addr_d[27:24];
                    end
                end
                S_SETUP: begin
                    state_q   <= S_ACCESS;
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                end
                S_ACCESS: begin
                    // A ready slave wins over a timeout reached in the same cycle.
                    if (PREADY) begin
                        state_q   <= S_DONE;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        done_q    <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
                        rdata_q   <= pwrite_q ? 32'd0 : PRDATA;
                        err_q     <= PSLVERR;
                    end else if (wait_q == 16'(TIMEOUT)) begin
                        state_q   <= S_DONE;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        done_q    <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        tev_q     <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= '0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    tev_q   <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign DONE       = done_q;
    assign RDATA      = rdata_q;
    assign ERR        = err_q;
    assign TIMEOUT_EV = tev_q;
    assign PADDR      = paddr_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PWDATA     = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench: completions are predicted into a queue and checked by an independent DONE monitor.
module tb_apb_master_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 4;

    logic                PCLK = 1'b0;
    logic                PRESET;
    logic [NREQ-1:0]     REQ;
    logic [NREQ-1:0]     REQ_WRITE;
    logic [NREQ*32-1:0]  REQ_ADDR;
    logic [NREQ*32-1:0]  REQ_WDATA;
    logic [NREQ-1:0]     DONE;
    logic [31:0]         RDATA;
    logic                ERR;
    logic                TIMEOUT_EV;
    logic [31:0]         PADDR;
    logic [15:0]         PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [31:0]         PWDATA;
    logic [31:0]         PRDATA;
    logic                PREADY;
    logic                PSLVERR;

    apb_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .DONE(DONE), .RDATA(RDATA),
        .ERR(ERR), .TIMEOUT_EV(TIMEOUT_EV), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        logic        tev;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   c0;
    int   npen;
    int   order[5] = '{0, 1, 2, 3, 0};

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic push(input int idx, input logic [31:0] rd, input logic e, input logic t, input int c);
        exp_t x;
        x.idx = idx; x.rdata = rd; x.err = e; x.tev = t; x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        REQ_WRITE[i]         = w;
        REQ_ADDR[32*i +: 32]  = a;
        REQ_WDATA[32*i +: 32] = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"},    32'(DONE), 0);
        chk({tag, "_rdata"},   RDATA, 0);
        chk({tag, "_err"},     32'(ERR), 0);
        chk({tag, "_tev"},     32'(TIMEOUT_EV), 0);
        chk({tag, "_paddr"},   PADDR, 0);
        chk({tag, "_psel"},    32'(PSEL), 0);
        chk({tag, "_penable"}, 32'(PENABLE), 0);
        chk({tag, "_pwrite"},  32'(PWRITE), 0);
        chk({tag, "_pwdata"},  PWDATA, 0);
    endtask

    task automatic do_reset;
        PRESET = 1'b1;
        repeat (2) tick;
        chk_all_zero("reset");
        PRESET = 1'b0;
        tick;
    endtask

    // Completion monitor
    always @(negedge PCLK) begin
        exp_t e;
        if (!PRESET) begin
            if (DONE != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: DONE=%b with no transfer expected (cycle %0d)", DONE, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_vec",   32'(DONE), 32'(1) << e.idx);
                    chk("rdata",      RDATA, e.rdata);
                    chk("err",        32'(ERR), 32'(e.err));
                    chk("timeout_ev", 32'(TIMEOUT_EV), 32'(e.tev));
                    chk("done_cycle", cyc, e.cyc);
                end
            end else if (TIMEOUT_EV) begin
                checks++;
                errors++;
                $display("FAIL stray_timeout_ev: TIMEOUT_EV=1 with DONE=0 (cycle %0d)", cyc);
            end
        end
    end

    initial begin
        PRESET = 1'b1; REQ = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
        PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
        do_reset;

        // Single zero-wait write from requester 0
        set_req(0, 1'b1, 32'h0300_0010, 32'hA5A5_0001);
        REQ[0] = 1'b1;
        c0 = cyc;
        push(0, 32'h0, 1'b0, 1'b0, c0 + 3);
        tick;
        chk("t1_setup_psel",    32'(PSEL), 32'h0008);
        chk("t1_setup_penable", 32'(PENABLE), 0);
        chk("t1_setup_pwrite",  32'(PWRITE), 1);
        chk("t1_setup_paddr",   PADDR, 32'h0300_0010);
        chk("t1_setup_pwdata",  PWDATA, 32'hA5A5_0001);
        REQ[0] = 1'b0;
        REQ_ADDR[31:0] = 32'hFFFF_FFFF;
        tick;
        chk("t1_access_penable", 32'(PENABLE), 1);
        chk("t1_access_psel",    32'(PSEL), 32'h0008);
        chk("t1_access_paddr",   PADDR, 32'h0300_0010);
        tick;
        chk("t1_done_psel",    32'(PSEL), 0);
        chk("t1_done_penable", 32'(PENABLE), 0);
        tick;

        // Read from requester 2 with three wait states
        c0 = cyc;
        set_req(2, 1'b0, 32'h0500_0100, 32'h0);
        REQ[2] = 1'b1;
        PREADY = 1'b0;
        PRDATA = 32'h1234_5678;
        push(2, 32'h1234_5678, 1'b0, 1'b0, c0 + 6);
        tick;
        chk("t2_setup_psel",   32'(PSEL), 32'h0020);
        chk("t2_setup_pwrite", 32'(PWRITE), 0);
        REQ[2] = 1'b0;
        npen = 0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (PENABLE) npen++;
            if (k == 3) PREADY = 1'b1;
        end
        tick;
        chk("t2_penable_cycles", npen, 4);
        chk("t2_done_penable",   32'(PENABLE), 0);
        tick;

        // All four requesters from reset: round-robin 0,1,2,3,0
        do_reset;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, {8'(i + 1), 24'h000040}, 32'(i));
        REQ = '1;
        c0 = cyc;
        for (int g = 0; g < 5; g++) push(order[g], 32'h0, 1'b0, 1'b0, c0 + 3 + 4 * g);
        for (int g = 0; g < 5; g++) begin
            repeat ((g == 0) ? 1 : 4) tick;
            chk("t3_grant_psel", 32'(PSEL), 32'(1) << (order[g] + 1));
            if (g == 4) REQ = '0;
        end
        repeat (3) tick;

        // Slave error on a zero-wait read
        c0 = cyc;
        set_req(1, 1'b0, 32'h0F00_0004, 32'h0);
        REQ[1] = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
        PSLVERR = 1'b1;
        push(1, 32'hDEAD_BEEF, 1'b1, 1'b0, c0 + 3);
        tick;
        chk("t4_setup_psel", 32'(PSEL), 32'h8000);
        REQ[1] = 1'b0;
        repeat (2) tick;
        PSLVERR = 1'b0;
        tick;

        // Timeout abort: PREADY held low
        c0 = cyc;
        set_req(3, 1'b0, 32'h0200_0000, 32'h0);
        REQ[3] = 1'b1;
        PREADY = 1'b0;
        PRDATA = 32'hFFFF_FFFF;
        push(3, 32'h0, 1'b1, 1'b1, c0 + 7);
        tick;
        REQ[3] = 1'b0;
        npen = 0;
        for (int k = 0; k < 5; k++) begin
            tick;
            if (PENABLE) npen++;
        end
        tick;
        chk("t5_access_cycles", npen, 5);
        chk("t5_done_psel",     32'(PSEL), 0);
        chk("t5_done_penable",  32'(PENABLE), 0);
        tick;

        // PREADY in the fifth ACCESS cycle completes normally
        c0 = cyc;
        set_req(0, 1'b0, 32'h0200_0008, 32'h0);
        REQ[0] = 1'b1;
        PRDATA = 32'h0BAD_F00D;
        push(0, 32'h0BAD_F00D, 1'b0, 1'b0, c0 + 7);
        tick;
        REQ[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            if (k == 4) PREADY = 1'b1;
        end
        tick;
        tick;

        // Reset during ACCESS drops the transfer; pending REQ[1] goes first afterwards
        c0 = cyc;
        set_req(2, 1'b1, 32'h0700_0000, 32'h5555_AAAA);
        REQ[2] = 1'b1;
        PREADY = 1'b0;
        tick;
        REQ[2] = 1'b0;
        tick;
        chk("t6_access_penable", 32'(PENABLE), 1);
        PRESET = 1'b1;
        set_req(1, 1'b1, 32'h0100_0020, 32'hCAFE_0001);
        REQ[1] = 1'b1;
        tick;
        chk_all_zero("t6_midreset");
        PRESET = 1'b0;
        PREADY = 1'b1;
        push(1, 32'h0, 1'b0, 1'b0, c0 + 6);
        tick;
        chk("t6_setup_psel",   32'(PSEL), 32'h0002);
        chk("t6_setup_paddr",  PADDR, 32'h0100_0020);
        chk("t6_setup_pwdata", PWDATA, 32'hCAFE_0001);
        REQ[1] = 1'b0;
        repeat (5) tick;

        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
